gf251_rej_sampler: RTL

//  Upstream operand source for gf251_mul. Consumes raw XOF/PRNG words and rejection-samples

---
 rtl/gf251_rej_sampler_if.sv | 22 ++
 rtl/gf251_rej_sampler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/gf251_rej_sampler_if.sv
// Stream bundle for gf251_rej_sampler: raw random words in, GF(251) elements out.
// The master side drives words and element acceptance; the slave side is the sampler.
interface gf251_rej_sampler_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/gf251_rej_sampler.sv
// Rejection sampler: scans random words byte by byte and emits N_ELEM uniform GF(251)
// elements per job on a valid/ready stream, then pulses done for one cycle.
module gf251_rej_sampler #(
  parameter int WIDTH  = 32,
  parameter int N_ELEM = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start,
  gf251_rej_sampler_if.slave    stream,
  output logic                  busy,
  output logic                  done
);
  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(N_ELEM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           nxt_state_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] nxt_word_s;
  logic [IW-1:0]    idx_r;
  logic [IW-1:0]    nxt_idx_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    nxt_cnt_s;
  logic [7:0]       cur_byte_s;
  logic [7:0]       nxt_byte_s;
  logic [7:0]       out_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             hs_s;
  logic             last_s;

  // A byte is a field element exactly when it is 0..250; 251..255 are rejected.
  function automatic logic in_field(input logic [7:0] b);
    return (b < 8'd251);
  endfunction

  // Decode the byte under the scan pointer and the element handshake.
  always_comb begin
    cur_byte_s = word_r[{idx_r, 3'b000} +: 8];
    accept_s   = in_field(cur_byte_s);
    hs_s       = (state_r == SCAN) && accept_s && stream.out_ready;
    last_s     = (idx_r == IW'(NB - 1));
  end

  // Next-state, word, index and count logic; also selects the byte visible next cycle.
  always_comb begin
    nxt_state_s = state_r;
    nxt_word_s  = word_r;
    nxt_idx_s   = idx_r;
    nxt_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nxt_state_s = LOAD;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      LOAD: begin
        if (stream.in_valid) begin
          nxt_word_s  = stream.in_word;
          nxt_idx_s   = {IW{1'b0}};
          nxt_state_s = SCAN;
        end else begin
          nxt_state_s = LOAD;
        end
      end
      SCAN: begin
        if (hs_s && (cnt_r == CW'(N_ELEM - 1))) begin
          // Job complete: any bytes left in the word are dropped.
          nxt_cnt_s   = cnt_r + CW'(1);
          nxt_state_s = DONE;
        end else if (hs_s || !accept_s) begin
          if (hs_s) begin
            nxt_cnt_s = cnt_r + CW'(1);
          end else begin
            nxt_cnt_s = cnt_r;
          end
          if (last_s) begin
            nxt_state_s = LOAD;
          end else begin
            nxt_idx_s   = idx_r + IW'(1);
            nxt_state_s = SCAN;
          end
        end else begin
          // Accepted byte waiting for out_ready: everything holds.
          nxt_state_s = SCAN;
        end
      end
      DONE: begin
        nxt_cnt_s   = {CW{1'b0}};
        nxt_state_s = IDLE;
      end
      default: begin
        nxt_cnt_s   = {CW{1'b0}};
        nxt_state_s = IDLE;
      end
    endcase
    nxt_byte_s = nxt_word_s[{nxt_idx_s, 3'b000} +: 8];
  end

  // State and datapath registers; outputs are registered from the next-state view.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= IDLE;
      word_r      <= {WIDTH{1'b0}};
      idx_r       <= {IW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_r       <= 8'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      word_r      <= nxt_word_s;
      idx_r       <= nxt_idx_s;
      cnt_r       <= nxt_cnt_s;
      out_valid_r <= (nxt_state_s == SCAN) && in_field(nxt_byte_s);
      out_r       <= ((nxt_state_s == SCAN) && in_field(nxt_byte_s)) ? nxt_byte_s : 8'd0;
      in_ready_r  <= (nxt_state_s == LOAD);
      busy_r      <= (nxt_state_s != IDLE);
      done_r      <= (nxt_state_s == DONE);
    end
  end

  assign stream.in_ready  = in_ready_r;
  assign stream.out       = out_r;
  assign stream.out_valid = out_valid_r;
  assign busy             = busy_r;
  assign done             = done_r;
endmodule
